// File: rtl/instr_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;

  localparam int PC_W_DEF   = 13;
  localparam int INST_W_DEF = 9;
  localparam int IA_W       = PC_W_DEF - 1;

endpackage

// File: rtl/instr_fetch_if.sv
// Harness/decoder/ROM bus of the fetch stage; icount only exists with FETCH_ICOUNT_EN.
interface instr_fetch_if #(
  parameter int PC_W   = 13,
  parameter int INST_W = 9,
  parameter int IC_W   = 16
) ();
  logic              start;
  logic [PC_W-2:0]   start_addr;
  logic              halt;
  logic              stall;
  logic              branch_en;
  logic [PC_W-2:0]   branch_target;
  logic [INST_W-1:0] imem_rdata;
  logic [PC_W-1:0]   PC;
  logic [PC_W-2:0]   imem_addr;
  logic              imem_en;
  logic [INST_W-1:0] inst_out;
  logic [INST_W-1:0] inst_q;
  logic              busy;
  logic              done;
`ifdef FETCH_ICOUNT_EN
  logic [IC_W-1:0]   icount;
`endif

  modport master (
    input  start, start_addr, halt, stall, branch_en, branch_target, imem_rdata,
    output PC, imem_addr, imem_en, inst_out, inst_q, busy, done
`ifdef FETCH_ICOUNT_EN
    , output icount
`endif
  );

  modport slave (
    output start, start_addr, halt, stall, branch_en, branch_target, imem_rdata,
    input  PC, imem_addr, imem_en, inst_out, inst_q, busy, done
`ifdef FETCH_ICOUNT_EN
    , input icount
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// Program sequencer / fetch stage: even PC = fetch phase, odd PC = execute phase.
// Optional retired-instruction counter enabled by FETCH_ICOUNT_EN.
module instr_fetch import fetch_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int IC_W   = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  instr_fetch_if.master  bus
);
  localparam int AW = PC_W - 1;

  fetch_state_t      state, nxt_state;
  logic [PC_W-1:0]   pc_q, nxt_pc, pc_inc;
  logic [AW-1:0]     ld_addr, nxt_ld;
  logic [INST_W-1:0] inst_q_r, nxt_inst_q;
  logic              busy_r, nxt_busy, done_r, nxt_done;
`ifdef FETCH_ICOUNT_EN
  logic [IC_W-1:0]   icnt, nxt_icnt;
`endif

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    nxt_state     = state;
    nxt_pc        = pc_q;
    nxt_ld        = ld_addr;
    nxt_inst_q    = inst_q_r;
    nxt_busy      = busy_r;
    nxt_done      = done_r;
    bus.imem_addr = pc_q[PC_W-1:1];
    bus.imem_en   = 1'b0;
    bus.inst_out  = '0;
`ifdef FETCH_ICOUNT_EN
    nxt_icnt      = icnt;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          nxt_state     = LOAD;
          nxt_ld        = bus.start_addr;
          bus.imem_addr = bus.start_addr;
          bus.imem_en   = 1'b1;
          nxt_busy      = 1'b1;
          nxt_done      = 1'b0;
`ifdef FETCH_ICOUNT_EN
          nxt_icnt      = '0;
`endif
        end
      end
      // ROM holds its output while disabled, so the first word is still valid in RUN.
      LOAD: begin
        nxt_pc    = {ld_addr, 1'b0};
        nxt_state = RUN;
      end
      RUN: begin
        bus.inst_out = bus.imem_rdata;
        if (!pc_q[0]) begin
          nxt_inst_q = bus.imem_rdata;
          nxt_pc     = pc_inc;
        end else begin
`ifdef FETCH_ICOUNT_EN
          if ((bus.halt || !bus.stall) && icnt != '1) nxt_icnt = icnt + IC_W'(1);
`endif
          if (bus.halt) begin
            nxt_state = DONE;
            nxt_busy  = 1'b0;
            nxt_done  = 1'b1;
          end else if (bus.stall) begin
            nxt_pc = pc_q;
          end else if (bus.branch_en) begin
            nxt_pc        = {bus.branch_target, 1'b0};
            bus.imem_addr = bus.branch_target;
            bus.imem_en   = 1'b1;
          end else begin
            nxt_pc        = pc_inc;
            bus.imem_addr = pc_inc[PC_W-1:1];
            bus.imem_en   = 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pc_q     <= '0;
      ld_addr  <= '0;
      inst_q_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef FETCH_ICOUNT_EN
      icnt     <= '0;
`endif
    end else begin
      state    <= nxt_state;
      pc_q     <= nxt_pc;
      ld_addr  <= nxt_ld;
      inst_q_r <= nxt_inst_q;
      busy_r   <= nxt_busy;
      done_r   <= nxt_done;
`ifdef FETCH_ICOUNT_EN
      icnt     <= nxt_icnt;
`endif
    end
  end

  assign bus.PC     = pc_q;
  assign bus.inst_q = inst_q_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
`ifdef FETCH_ICOUNT_EN
  assign bus.icount = icnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch with a ROM model and an inst_out scoreboard.
module tb_instr_fetch;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;

  instr_fetch_if #(.PC_W(13), .INST_W(9), .IC_W(16)) bus ();
  instr_fetch #(.PC_W(13), .INST_W(9), .IC_W(16)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  logic [8:0] rom [4096];
  always @(posedge CLK) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

  typedef struct {
    logic        st;
    logic [11:0] sa;
    logic        h, s, b;
    logic [11:0] bt;
    logic [12:0] pc;
    logic        en;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl [23];
  int   nv = 0;
  logic [11:0] run_sa [5];
  int   run_lo [5];
  int   run_hi [5];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [8:0] exp_q [$];
  logic busy_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic add(input logic st, input logic [11:0] sa, input logic h, input logic s,
                     input logic b, input logic [11:0] bt, input logic [12:0] pc,
                     input logic en, input logic [11:0] addr);
    tbl[nv] = '{st, sa, h, s, b, bt, pc, en, addr};
    nv++;
  endtask

  // Scoreboard sink: every fetch-phase RUN cycle must match the next expected word.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (bus.busy && busy_d && !bus.PC[0]) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected_fetch: got inst_out %0h at PC %0h expected no fetch", bus.inst_out, bus.PC);
      end else begin
        e = exp_q.pop_front();
        chk("inst_out", {23'd0, bus.inst_out}, {23'd0, e});
      end
    end
    busy_d = bus.busy;
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.start_addr = '0; bus.halt = 1'b0; bus.stall = 1'b0;
    bus.branch_en = 1'b0; bus.branch_target = '0;
  endtask

  task automatic do_start(input logic [11:0] a);
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.start_addr = a;
    @(negedge CLK);
    chk("start_imem_en", {31'd0, bus.imem_en}, 32'd1);
    chk("start_imem_addr", {20'd0, bus.imem_addr}, {20'd0, a});
    @(posedge CLK); #1;
    bus.start = 1'b0;
    @(negedge CLK);
    chk("load_busy", {31'd0, bus.busy}, 32'd1);
    chk("load_done", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int ic;
    for (int i = 0; i < 4096; i++) rom[i] = 9'((i * 37 + 5) & 'h1FF);
    rom[16] = 9'h101; rom[17] = 9'h0A2; rom[18] = 9'h1FF; rom[256] = 9'h0C3;
    bus.imem_rdata = '0;
    idle_inputs();

    // run A: straight-line fetch
    run_sa[0] = 12'h010; run_lo[0] = nv;
    add(0,0,0,0,0,0, 13'h020, 0, 0);
    add(0,0,0,0,0,0, 13'h021, 1, 12'h011);
    add(0,0,0,0,0,0, 13'h022, 0, 0);
    add(0,0,0,0,0,0, 13'h023, 1, 12'h012);
    add(0,0,0,0,0,0, 13'h024, 0, 0);
    add(0,0,1,0,0,0, 13'h025, 0, 0);
    run_hi[0] = nv - 1;
    // run B: branch
    run_sa[1] = 12'h010; run_lo[1] = nv;
    add(0,0,0,0,0,0,       13'h020, 0, 0);
    add(0,0,0,0,1,12'h100, 13'h021, 1, 12'h100);
    add(0,0,0,0,0,0,       13'h200, 0, 0);
    add(0,0,1,0,0,0,       13'h201, 0, 0);
    run_hi[1] = nv - 1;
    // run C: 3-cycle stall, start pulse while busy
    run_sa[2] = 12'h018; run_lo[2] = nv;
    add(0,0,      0,0,0,0, 13'h030, 0, 0);
    add(1,12'h0AA,0,1,0,0, 13'h031, 0, 0);
    add(0,0,      0,1,1,12'h077, 13'h031, 0, 0);
    add(0,0,      0,1,0,0, 13'h031, 0, 0);
    add(0,0,      0,0,0,0, 13'h031, 1, 12'h019);
    add(0,0,      0,0,0,0, 13'h032, 0, 0);
    add(0,0,      1,0,0,0, 13'h033, 0, 0);
    run_hi[2] = nv - 1;
    // run D: halt beats branch
    run_sa[3] = 12'h020; run_lo[3] = nv;
    add(0,0,0,0,0,0,       13'h040, 0, 0);
    add(0,0,1,0,1,12'h155, 13'h041, 0, 0);
    run_hi[3] = nv - 1;
    // run E: PC wrap
    run_sa[4] = 12'hFFF; run_lo[4] = nv;
    add(0,0,0,0,0,0, 13'h1FFE, 0, 0);
    add(0,0,0,0,0,0, 13'h1FFF, 1, 12'h000);
    add(0,0,0,0,0,0, 13'h0000, 0, 0);
    add(0,0,1,0,0,0, 13'h0001, 0, 0);
    run_hi[4] = nv - 1;

    #1 RST_N = 1'b0;
    #2;
    chk("rst_pc", {19'd0, bus.PC}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    chk("rst_inst_q", {23'd0, bus.inst_q}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // asynchronous reset in the middle of RUN
    do_start(12'h012);
    @(posedge CLK); #1;
    exp_q.push_back(rom[12'h012]);
    @(negedge CLK);
    chk("pre_rst_pc", {19'd0, bus.PC}, 32'h024);
    @(posedge CLK); #1;
    chk("pre_rst_pc_odd", {19'd0, bus.PC}, 32'h025);
    #1 RST_N = 1'b0;
    #1;
    chk("async_rst_pc", {19'd0, bus.PC}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    @(negedge CLK) RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_no_read", {31'd0, bus.imem_en}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    for (int r = 0; r < 5; r++) begin
      ic = 0;
      do_start(run_sa[r]);
      for (int i = run_lo[r]; i <= run_hi[r]; i++) begin
        @(posedge CLK); #1;
        bus.start = tbl[i].st; bus.start_addr = tbl[i].sa;
        bus.halt = tbl[i].h; bus.stall = tbl[i].s;
        bus.branch_en = tbl[i].b; bus.branch_target = tbl[i].bt;
        if (!tbl[i].pc[0]) exp_q.push_back(rom[tbl[i].pc[12:1]]);
        else if (tbl[i].h || !tbl[i].s) ic++;
        @(negedge CLK);
        chk($sformatf("pc[%0d]", i), {19'd0, bus.PC}, {19'd0, tbl[i].pc});
        chk($sformatf("imem_en[%0d]", i), {31'd0, bus.imem_en}, {31'd0, tbl[i].en});
        if (tbl[i].en)
          chk($sformatf("imem_addr[%0d]", i), {20'd0, bus.imem_addr}, {20'd0, tbl[i].addr});
        if (tbl[i].pc[0])
          chk($sformatf("inst_q[%0d]", i), {23'd0, bus.inst_q}, {23'd0, rom[tbl[i].pc[12:1]]});
      end
      @(posedge CLK); #1;
      idle_inputs();
      @(negedge CLK);
      chk($sformatf("run%0d_done", r), {31'd0, bus.done}, 32'd1);
      chk($sformatf("run%0d_busy", r), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("run%0d_pc_hold", r), {19'd0, bus.PC}, {19'd0, tbl[run_hi[r]].pc});
`ifdef FETCH_ICOUNT_EN
      chk($sformatf("run%0d_icount", r), {16'd0, bus.icount}, ic);
`endif
      @(negedge CLK);
      chk($sformatf("run%0d_done_held", r), {31'd0, bus.done}, 32'd1);
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
